uart_rx_ctrl: RTL and testbench

//  Frame-sequencing controller for the UART receiver; CLK runs at Prescale x baud.

---
 rtl/uart_rx_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver frame-sequencing controller.
// The clock runs at Prescale x baud. This block finds the start edge and
// keeps the edge/bit counters. It pulses the checker and deserializer strobes
// on the second-to-last sample of each bit, and reads the registered checker
// results on the last sample. Outputs decode registered state only.
module uart_rx_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [PRESCALE_W-1:0]   edge_reg;
  logic [3:0]              bit_reg;
  logic [PRESCALE_W-1:0]   p_reg;         // Prescale latched at start detect
  logic                    par_en_reg;    // PAR_EN latched at start detect
  logic                    par_flag_reg;  // sticky parity error for this frame
  logic                    stp_flag_reg;  // stop error for this frame

  logic [PRESCALE_W-1:0]   last_edge;
  logic [PRESCALE_W-1:0]   chk_edge;
  logic                    bit_end;
  logic                    waiting;
  logic                    start_det;

  // The latched ratio sets the bit length, so a Prescale change mid-frame
  // only takes effect at the next start detect.
  assign last_edge = p_reg - PRESCALE_W'(1);
  assign chk_edge  = p_reg - PRESCALE_W'(2);
  assign bit_end   = (edge_reg == last_edge);
  // DONE behaves like IDLE, so a start bit that directly follows the stop bit is caught.
  assign waiting   = (state_reg == IDLE) || (state_reg == DONE);
  assign start_det = waiting && !RX_IN;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; transitions out of a bit happen on its last sample
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!RX_IN) state_next = START;
      end
      START: begin
        if (bit_end) state_next = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_reg == 4'(DATA_W))) begin
          state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = DONE;
      end
      DONE: begin
        state_next = RX_IN ? IDLE : START;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge/bit counters and frame configuration latch; the detect cycle is edge 0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_reg   <= '0;
      bit_reg    <= '0;
      p_reg      <= '0;
      par_en_reg <= 1'b0;
    end else if (waiting) begin
      bit_reg <= '0;
      if (!RX_IN) begin
        edge_reg   <= PRESCALE_W'(1);
        p_reg      <= Prescale;
        par_en_reg <= PAR_EN;
      end else begin
        edge_reg <= '0;
      end
    end else if (bit_end) begin
      edge_reg <= '0;
      // A glitching start bit abandons the frame with the counters cleared.
      if ((state_reg == START) && strt_glitch) begin
        bit_reg <= '0;
      end else begin
        bit_reg <= bit_reg + 4'd1;
      end
    end else begin
      edge_reg <= edge_reg + PRESCALE_W'(1);
    end
  end

  // Error flags capture the checker results on the last sample of each bit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_flag_reg <= 1'b0;
      stp_flag_reg <= 1'b0;
    end else if (start_det) begin
      par_flag_reg <= 1'b0;
      stp_flag_reg <= 1'b0;
    end else if (bit_end && (state_reg == PARITY)) begin
      par_flag_reg <= par_flag_reg | par_err;
    end else if (bit_end && (state_reg == STOP)) begin
      stp_flag_reg <= stp_err;
    end
  end

  // Output decode from registered state, counters and flags only
  always_comb begin
    dat_samp_en = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;
    case (state_reg)
      START: begin
        dat_samp_en = 1'b1;
        strt_chk_en = (edge_reg == chk_edge);
      end
      DATA: begin
        dat_samp_en = 1'b1;
        deser_en    = (edge_reg == chk_edge);
      end
      PARITY: begin
        dat_samp_en = 1'b1;
        par_chk_en  = (edge_reg == chk_edge);
      end
      STOP: begin
        dat_samp_en = 1'b1;
        stp_chk_en  = (edge_reg == chk_edge);
      end
      DONE: begin
        data_valid = !par_flag_reg && !stp_flag_reg;
        frame_err  = par_flag_reg || stp_flag_reg;
      end
      default: ;
    endcase
  end

  assign edge_cnt = edge_reg;
  assign bit_cnt  = bit_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. The bench plays each frame on RX_IN one
// clock per sample. It tallies the DUT strobes per cycle and compares them
// against cycle numbers worked out by hand. Cycle 0 is the start-detect cycle.
module tb_uart_rx_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       deser_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       frame_err;

  uart_rx_ctrl #(.DATA_W(8), .PRESCALE_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Per-run observations
  int   log_edge [0:1023];
  int   log_bit  [0:1023];
  logic log_samp [0:1023];
  int   n_dv, first_dv, last_dv;
  int   n_fe, first_fe;
  int   n_deser, n_deser_bad;
  int   n_strt, first_strt;
  int   n_par, first_par;
  int   n_stp, first_stp;
  int   n_samp, n_both;
  logic [7:0] frame_data [0:1];

  // Plays up to nfr frames (or a glitch of glitch_len low cycles) and records outputs.
  // Prescale switches to pchg_val after the sample of cycle pchg_cycle.
  task automatic run_frames(input int p, input int par, input int nfr, input int glitch_len,
                            input int cycles, input int pchg_cycle, input logic [5:0] pchg_val);
    int   len;
    int   fr;
    int   k;
    int   b;
    logic rx;
    len = ((par != 0) ? 11 : 10) * p;
    n_dv = 0; first_dv = -1; last_dv = -1;
    n_fe = 0; first_fe = -1;
    n_deser = 0; n_deser_bad = 0;
    n_strt = 0; first_strt = -1;
    n_par = 0; first_par = -1;
    n_stp = 0; first_stp = -1;
    n_samp = 0; n_both = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      log_edge[c] = int'(edge_cnt);
      log_bit[c]  = int'(bit_cnt);
      log_samp[c] = dat_samp_en;
      if (data_valid) begin
        if (n_dv == 0) first_dv = c;
        last_dv = c;
        n_dv++;
      end
      if (frame_err) begin
        if (n_fe == 0) first_fe = c;
        n_fe++;
      end
      if (deser_en) begin
        n_deser++;
        if (int'(edge_cnt) != p - 2) n_deser_bad++;
      end
      if (strt_chk_en) begin
        if (n_strt == 0) first_strt = c;
        n_strt++;
      end
      if (par_chk_en) begin
        if (n_par == 0) first_par = c;
        n_par++;
      end
      if (stp_chk_en) begin
        if (n_stp == 0) first_stp = c;
        n_stp++;
      end
      if (dat_samp_en) n_samp++;
      if (data_valid && frame_err) n_both++;
      if (glitch_len > 0) begin
        rx = (c < glitch_len) ? 1'b0 : 1'b1;
      end else begin
        fr = c / len;
        k  = c % len;
        b  = k / p;
        if (fr >= nfr)                rx = 1'b1;
        else if (b == 0)              rx = 1'b0;
        else if (b <= 8)              rx = frame_data[fr][b-1];
        else if (par != 0 && b == 9)  rx = ^frame_data[fr];
        else                          rx = 1'b1;
      end
      RX_IN = rx;
      if (c == pchg_cycle) Prescale = pchg_val;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    logic [16:0] outs;
    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (2) @(negedge CLK);
    outs = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
            stp_chk_en, data_valid, frame_err};
    tests_run++;
    if (outs !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    RST = 1'b1;
    idle(3);
    tests_run++;
    if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: samp=%b edge=%0d expected 0/0", dat_samp_en, edge_cnt);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic;
    Prescale = 6'd8; PAR_EN = 1'b0;
    frame_data[0] = 8'hA5;
    run_frames(8, 0, 1, 0, 100, -1, 6'd0);
    tests_run++; if (n_deser != 8) begin tests_failed++; $display("FAIL basic_deser_cnt: got %0d expected 8", n_deser); end
    tests_run++; if (n_deser_bad != 0) begin tests_failed++; $display("FAIL basic_deser_edge: %0d pulses off edge 6, expected 0", n_deser_bad); end
    tests_run++; if (n_dv != 1) begin tests_failed++; $display("FAIL basic_dv_cnt: got %0d expected 1", n_dv); end
    tests_run++; if (first_dv != 80) begin tests_failed++; $display("FAIL basic_dv_cycle: got %0d expected 80", first_dv); end
    tests_run++; if (n_fe != 0) begin tests_failed++; $display("FAIL basic_fe_cnt: got %0d expected 0", n_fe); end
    tests_run++; if (n_strt != 1 || first_strt != 6) begin tests_failed++; $display("FAIL basic_strt_chk: cnt %0d at %0d expected 1 at 6", n_strt, first_strt); end
    tests_run++; if (n_stp != 1 || first_stp != 78) begin tests_failed++; $display("FAIL basic_stp_chk: cnt %0d at %0d expected 1 at 78", n_stp, first_stp); end
    tests_run++; if (n_par != 0) begin tests_failed++; $display("FAIL basic_par_chk: got %0d expected 0", n_par); end
    tests_run++; if (n_samp != 79) begin tests_failed++; $display("FAIL basic_samp_cnt: got %0d expected 79", n_samp); end
    tests_run++; if (log_edge[1] != 1 || log_edge[7] != 7 || log_edge[8] != 0) begin tests_failed++; $display("FAIL basic_edge_seq: got %0d/%0d/%0d expected 1/7/0", log_edge[1], log_edge[7], log_edge[8]); end
    tests_run++; if (log_bit[7] != 0 || log_bit[8] != 1 || log_bit[39] != 4) begin tests_failed++; $display("FAIL basic_bit_seq: got %0d/%0d/%0d expected 0/1/4", log_bit[7], log_bit[8], log_bit[39]); end
    tests_run++; if (log_samp[80] !== 1'b0 || log_samp[81] !== 1'b0) begin tests_failed++; $display("FAIL basic_done_samp: got %b/%b expected 0/0", log_samp[80], log_samp[81]); end
    $display("[TB] test_basic frame 0xA5 P=8: dv=%0d at %0d", n_dv, first_dv);
  endtask

  task automatic test_glitch;
    idle(2);
    Prescale = 6'd16; PAR_EN = 1'b0; strt_glitch = 1'b1;
    run_frames(16, 0, 1, 3, 60, -1, 6'd0);
    strt_glitch = 1'b0;
    tests_run++; if (n_strt != 1 || first_strt != 14) begin tests_failed++; $display("FAIL glitch_strt_chk: cnt %0d at %0d expected 1 at 14", n_strt, first_strt); end
    tests_run++; if (log_samp[15] !== 1'b1 || log_edge[15] != 15) begin tests_failed++; $display("FAIL glitch_last_edge: samp=%b edge=%0d expected 1/15", log_samp[15], log_edge[15]); end
    tests_run++; if (log_samp[16] !== 1'b0 || log_edge[16] != 0 || log_bit[16] != 0) begin tests_failed++; $display("FAIL glitch_abort: samp=%b edge=%0d bit=%0d expected 0/0/0", log_samp[16], log_edge[16], log_bit[16]); end
    tests_run++; if (n_deser != 0 || n_dv != 0 || n_fe != 0) begin tests_failed++; $display("FAIL glitch_no_frame: deser=%0d dv=%0d fe=%0d expected 0/0/0", n_deser, n_dv, n_fe); end
    tests_run++; if (n_samp != 15) begin tests_failed++; $display("FAIL glitch_samp_cnt: got %0d expected 15", n_samp); end
    $display("[TB] test_glitch P=16: aborted after %0d sampling cycles", n_samp);
  endtask

  task automatic test_parity_err;
    idle(2);
    Prescale = 6'd8; PAR_EN = 1'b1; par_err = 1'b1;
    frame_data[0] = 8'h5A;
    run_frames(8, 1, 1, 0, 100, -1, 6'd0);
    par_err = 1'b0; PAR_EN = 1'b0;
    tests_run++; if (n_par != 1 || first_par != 78) begin tests_failed++; $display("FAIL par_chk: cnt %0d at %0d expected 1 at 78", n_par, first_par); end
    tests_run++; if (n_stp != 1 || first_stp != 86) begin tests_failed++; $display("FAIL par_stp_chk: cnt %0d at %0d expected 1 at 86", n_stp, first_stp); end
    tests_run++; if (n_fe != 1 || first_fe != 88) begin tests_failed++; $display("FAIL par_frame_err: cnt %0d at %0d expected 1 at 88", n_fe, first_fe); end
    tests_run++; if (n_dv != 0) begin tests_failed++; $display("FAIL par_dv: got %0d expected 0", n_dv); end
    tests_run++; if (n_deser != 8) begin tests_failed++; $display("FAIL par_deser_cnt: got %0d expected 8", n_deser); end
    $display("[TB] test_parity_err frame 0x5A P=8: fe at %0d", first_fe);
  endtask

  task automatic test_back_to_back;
    idle(2);
    Prescale = 6'd32; PAR_EN = 1'b0;
    frame_data[0] = 8'h3C;
    frame_data[1] = 8'hC3;
    run_frames(32, 0, 2, 0, 660, -1, 6'd0);
    tests_run++; if (n_dv != 2) begin tests_failed++; $display("FAIL b2b_dv_cnt: got %0d expected 2", n_dv); end
    tests_run++; if (first_dv != 320 || last_dv != 640) begin tests_failed++; $display("FAIL b2b_dv_cycles: got %0d,%0d expected 320,640", first_dv, last_dv); end
    tests_run++; if (log_edge[321] != 1 || log_bit[321] != 0 || log_samp[321] !== 1'b1) begin tests_failed++; $display("FAIL b2b_restart: edge=%0d bit=%0d samp=%b expected 1/0/1", log_edge[321], log_bit[321], log_samp[321]); end
    tests_run++; if (n_deser != 16 || n_deser_bad != 0) begin tests_failed++; $display("FAIL b2b_deser: cnt %0d bad %0d expected 16/0", n_deser, n_deser_bad); end
    tests_run++; if (n_fe != 0 || n_both != 0) begin tests_failed++; $display("FAIL b2b_fe: fe=%0d both=%0d expected 0/0", n_fe, n_both); end
    $display("[TB] test_back_to_back P=32 frames 0x3C,0xC3: dv at %0d and %0d", first_dv, last_dv);
  endtask

  task automatic test_reset_mid_frame;
    logic [16:0] outs;
    idle(2);
    Prescale = 6'd8; PAR_EN = 1'b0;
    frame_data[0] = 8'h3C;
    run_frames(8, 0, 1, 0, 35, -1, 6'd0);
    tests_run++; if (log_bit[34] != 4 || log_samp[34] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre: bit=%0d samp=%b expected 4/1", log_bit[34], log_samp[34]); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    outs = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
            stp_chk_en, data_valid, frame_err};
    tests_run++; if (outs !== 17'd0) begin tests_failed++; $display("FAIL rstmid_async: got %h expected 0", outs); end
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    idle(3);
    run_frames(8, 0, 1, 0, 100, -1, 6'd0);
    tests_run++; if (n_dv != 1 || first_dv != 80) begin tests_failed++; $display("FAIL rstmid_clean: dv cnt %0d at %0d expected 1 at 80", n_dv, first_dv); end
    tests_run++; if (n_fe != 0) begin tests_failed++; $display("FAIL rstmid_fe: got %0d expected 0", n_fe); end
    $display("[TB] test_reset_mid_frame frame 0x3C: dv at %0d", first_dv);
  endtask

  task automatic test_stop_err_prescale;
    idle(2);
    Prescale = 6'd8; PAR_EN = 1'b0; stp_err = 1'b1;
    frame_data[0] = 8'h96;
    run_frames(8, 0, 1, 0, 100, 20, 6'd16);
    stp_err = 1'b0;
    tests_run++; if (n_fe != 1 || first_fe != 80) begin tests_failed++; $display("FAIL stp_frame_err: cnt %0d at %0d expected 1 at 80", n_fe, first_fe); end
    tests_run++; if (n_dv != 0) begin tests_failed++; $display("FAIL stp_dv: got %0d expected 0", n_dv); end
    tests_run++; if (n_deser != 8 || n_deser_bad != 0) begin tests_failed++; $display("FAIL stp_deser: cnt %0d bad %0d expected 8/0", n_deser, n_deser_bad); end
    $display("[TB] test_stop_err_prescale frame 0x96: fe at %0d", first_fe);
    // The new ratio takes effect at the next start detect.
    idle(2);
    frame_data[0] = 8'h0F;
    run_frames(16, 0, 1, 0, 180, -1, 6'd0);
    tests_run++; if (n_dv != 1 || first_dv != 160) begin tests_failed++; $display("FAIL newp_dv: cnt %0d at %0d expected 1 at 160", n_dv, first_dv); end
    tests_run++; if (n_deser != 8 || n_deser_bad != 0 || n_fe != 0) begin tests_failed++; $display("FAIL newp_deser: cnt %0d bad %0d fe %0d expected 8/0/0", n_deser, n_deser_bad, n_fe); end
    $display("[TB] test_new_prescale frame 0x0F P=16: dv at %0d", first_dv);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_parity_err;
    test_back_to_back;
    test_reset_mid_frame;
    test_stop_err_prescale;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation still running at 1ms, expected completion");
    $fatal(1, "timeout");
  end

endmodule
